// File: rtl/rgb2gray_pkg.sv
`default_nettype none
// rgb2gray_pkg: shared types and default constants for the rgb2gray frame controller.
// Rev 1.0
package rgb2gray_pkg;

  localparam int PIX_W             = 8;
  localparam int DEF_DIM_W         = 12;
  localparam int DEF_DRAIN_TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rgb2gray_frame_ctrl_if.sv
`default_nettype none
// rgb2gray_frame_ctrl_if: control, upstream pixel, converter and downstream gray signals.
// Rev 1.0
interface rgb2gray_frame_ctrl_if #(
  parameter int DIM_W = rgb2gray_pkg::DEF_DIM_W
);

  logic                            start;
  logic [DIM_W-1:0]                cfg_width;
  logic [DIM_W-1:0]                cfg_height;
  logic                            busy;
  logic                            done;
  logic                            err_timeout;

  logic                            s_valid;
  logic                            s_ready;
  logic [rgb2gray_pkg::PIX_W-1:0]  s_r;
  logic [rgb2gray_pkg::PIX_W-1:0]  s_g;
  logic [rgb2gray_pkg::PIX_W-1:0]  s_b;

  logic                            cv_din_valid;
  logic [rgb2gray_pkg::PIX_W-1:0]  cv_r;
  logic [rgb2gray_pkg::PIX_W-1:0]  cv_g;
  logic [rgb2gray_pkg::PIX_W-1:0]  cv_b;
  logic                            cv_dout_valid;
  logic [rgb2gray_pkg::PIX_W-1:0]  cv_gray;

  logic                            m_valid;
  logic [rgb2gray_pkg::PIX_W-1:0]  m_gray;
  logic                            m_sof;
  logic                            m_eol;
  logic                            m_eof;

  // Controller side
  modport slave (
    input  start, cfg_width, cfg_height,
    input  s_valid, s_r, s_g, s_b,
    input  cv_dout_valid, cv_gray,
    output busy, done, err_timeout,
    output s_ready,
    output cv_din_valid, cv_r, cv_g, cv_b,
    output m_valid, m_gray, m_sof, m_eol, m_eof
  );

  // Environment side
  modport master (
    output start, cfg_width, cfg_height,
    output s_valid, s_r, s_g, s_b,
    output cv_dout_valid, cv_gray,
    input  busy, done, err_timeout,
    input  s_ready,
    input  cv_din_valid, cv_r, cv_g, cv_b,
    input  m_valid, m_gray, m_sof, m_eol, m_eof
  );

endinterface
`default_nettype wire

// File: rtl/rgb2gray_pos_cnt.sv
`default_nettype none
// rgb2gray_pos_cnt: x/y raster position counter reporting first pixel, end of line, end of frame.
// Rev 1.0
module rgb2gray_pos_cnt #(
  parameter int DIM_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [DIM_W-1:0] width,
  input  logic [DIM_W-1:0] height,
  output logic             sof,
  output logic             eol,
  output logic             eof
);

  logic [DIM_W-1:0] x;
  logic [DIM_W-1:0] y;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (eol) begin
        x <= '0;
        y <= eof ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

  // Flags describe the pixel about to be counted, so callers sample them with en.
  assign sof = (x == '0) && (y == '0);
  assign eol = (x == width - 1'b1);
  assign eof = eol && (y == height - 1'b1);

endmodule
`default_nettype wire

// File: rtl/rgb2gray_frame_ctrl.sv
`default_nettype none
// rgb2gray_frame_ctrl: sequences one frame of pixels through rgb2gray and frames the results.
// Rev 1.0
module rgb2gray_frame_ctrl
  import rgb2gray_pkg::*;
#(
  parameter int DIM_W         = DEF_DIM_W,
  parameter int DRAIN_TIMEOUT = DEF_DRAIN_TIMEOUT
) (
  input logic                 clk,
  input logic                 rst,
  rgb2gray_frame_ctrl_if.slave bus
);

  localparam int CNT_W = 2 * DIM_W;
  localparam int WD_W  = $clog2(DRAIN_TIMEOUT + 1);

  state_t           state;
  state_t           state_nx;
  logic [DIM_W-1:0] width_q;
  logic [DIM_W-1:0] height_q;
  logic [CNT_W-1:0] total;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [WD_W-1:0]  wdog;

  logic start_ok;
  logic cfg_zero;
  logic hs;
  logic res_ok;
  logic drain_ok;
  logic wd_expired;
  logic in_sof;
  logic in_eol;
  logic in_eof;
  logic out_sof;
  logic out_eol;
  logic out_eof;
  logic unused_in_flags;

  assign start_ok   = (state == IDLE) && bus.start;
  assign cfg_zero   = (bus.cfg_width == '0) || (bus.cfg_height == '0);
  assign bus.s_ready = (state == RUN) && (in_cnt < total);
  assign hs         = bus.s_valid && bus.s_ready;
  assign res_ok     = bus.cv_dout_valid && ((state == RUN) || (state == DRAIN)) && (out_cnt < total);
  assign drain_ok   = (out_cnt == total);
  assign wd_expired = (wdog == WD_W'(DRAIN_TIMEOUT - 1));
  assign unused_in_flags = in_sof | in_eol;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nx = cfg_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs && in_eof) begin
          state_nx = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_ok || wd_expired) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Frame configuration, pixel counters and drain watchdog.
  always_ff @(posedge clk) begin
    if (rst) begin
      width_q         <= '0;
      height_q        <= '0;
      total           <= '0;
      in_cnt          <= '0;
      out_cnt         <= '0;
      wdog            <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      if (start_ok) begin
        width_q         <= bus.cfg_width;
        height_q        <= bus.cfg_height;
        total           <= {{DIM_W{1'b0}}, bus.cfg_width} * {{DIM_W{1'b0}}, bus.cfg_height};
        in_cnt          <= '0;
        out_cnt         <= '0;
        bus.err_timeout <= 1'b0;
      end
      if (hs) begin
        in_cnt <= in_cnt + 1'b1;
      end
      if (res_ok) begin
        out_cnt <= out_cnt + 1'b1;
      end
      if (state == DRAIN) begin
        wdog <= wdog + 1'b1;
        if (wd_expired && !drain_ok) begin
          bus.err_timeout <= 1'b1;
        end
      end else begin
        wdog <= '0;
      end
    end
  end

  // busy mirrors the state the FSM is entering, so it rises right after the accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
    end else begin
      bus.busy <= (state_nx != IDLE);
      bus.done <= (state == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.cv_din_valid <= 1'b0;
      bus.cv_r         <= '0;
      bus.cv_g         <= '0;
      bus.cv_b         <= '0;
    end else begin
      bus.cv_din_valid <= hs;
      if (hs) begin
        bus.cv_r <= bus.s_r;
        bus.cv_g <= bus.s_g;
        bus.cv_b <= bus.s_b;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.m_valid <= 1'b0;
      bus.m_gray  <= '0;
      bus.m_sof   <= 1'b0;
      bus.m_eol   <= 1'b0;
      bus.m_eof   <= 1'b0;
    end else begin
      bus.m_valid <= res_ok;
      bus.m_sof   <= res_ok && out_sof;
      bus.m_eol   <= res_ok && out_eol;
      bus.m_eof   <= res_ok && out_eof;
      if (res_ok) begin
        bus.m_gray <= bus.cv_gray;
      end
    end
  end

  rgb2gray_pos_cnt #(.DIM_W(DIM_W)) u_in_pos (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .en     (hs),
    .width  (width_q),
    .height (height_q),
    .sof    (in_sof),
    .eol    (in_eol),
    .eof    (in_eof)
  );

  rgb2gray_pos_cnt #(.DIM_W(DIM_W)) u_out_pos (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_ok),
    .en     (res_ok),
    .width  (width_q),
    .height (height_q),
    .sof    (out_sof),
    .eol    (out_eol),
    .eof    (out_eof)
  );

endmodule
`default_nettype wire

// File: tb/tb_rgb2gray_frame_ctrl.sv
`default_nettype none
// tb_rgb2gray_frame_ctrl: directed frames through the controller with a behavioural rgb2gray in the loop.
// Rev 1.0
module tb_rgb2gray_frame_ctrl;

  localparam int DIM_W = 12;
  localparam int TO    = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb2gray_frame_ctrl_if #(.DIM_W(DIM_W)) bus ();

  rgb2gray_frame_ctrl #(.DIM_W(DIM_W), .DRAIN_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Behavioural converter: 0 = in the loop, 1 = never answers, 2 = manual pulses.
  int   mode      = 0;
  logic man_pulse = 1'b0;

  function automatic logic [7:0] gray_of(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    int s;
    s = 77 * r + 150 * g + 29 * b;
    return s[15:8];
  endfunction

  always @(posedge clk) begin
    case (mode)
      0: begin
        bus.cv_dout_valid <= bus.cv_din_valid;
        bus.cv_gray       <= gray_of(bus.cv_r, bus.cv_g, bus.cv_b);
      end
      1: begin
        bus.cv_dout_valid <= 1'b0;
        bus.cv_gray       <= 8'h00;
      end
      default: begin
        bus.cv_dout_valid <= man_pulse;
        bus.cv_gray       <= 8'hAA;
      end
    endcase
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_out, n_din, n_hs, n_done, n_sready, n_align, run, max_run, done_cyc;
  logic [31:0] sof_m, eol_m, eof_m;
  logic [7:0]  g_and, g_or, last_gray;
  logic        prev_hs = 1'b0;

  task automatic clr_stats();
    n_out = 0; n_din = 0; n_hs = 0; n_done = 0; n_sready = 0; n_align = 0;
    run = 0; max_run = 0; done_cyc = 0;
    sof_m = '0; eol_m = '0; eof_m = '0;
    g_and = 8'hFF; g_or = 8'h00; last_gray = 8'h00;
  endtask

  always @(negedge clk) begin
    if (bus.s_valid && bus.s_ready) n_hs++;
    if (bus.s_ready) n_sready++;
    if (bus.cv_din_valid) begin
      n_din++;
      run++;
      if (prev_hs) n_align++;
      if (run > max_run) max_run = run;
    end else begin
      run = 0;
    end
    prev_hs = bus.s_valid && bus.s_ready;
    if (bus.m_valid) begin
      if (n_out < 32) begin
        sof_m[n_out] = bus.m_sof;
        eol_m[n_out] = bus.m_eol;
        eof_m[n_out] = bus.m_eof;
      end
      g_and     = g_and & bus.m_gray;
      g_or      = g_or | bus.m_gray;
      last_gray = bus.m_gray;
      n_out++;
    end
    if (bus.done) begin
      n_done++;
      done_cyc = cyc;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int start_cyc;

  task automatic do_start(input int w, input int h);
    bus.cfg_width  = DIM_W'(w);
    bus.cfg_height = DIM_W'(h);
    bus.start      = 1'b1;
    start_cyc      = cyc;
    tick();
    bus.start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      if (bus.done) break;
      tick();
    end
    check(tag, 32'(k < budget), 32'd1);
  endtask

  task automatic set_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    bus.s_r = r; bus.s_g = g; bus.s_b = b;
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_width = '0; bus.cfg_height = '0;
    bus.s_valid = 1'b0; set_pix(8'd0, 8'd0, 8'd0);
    clr_stats();

    // Reset state
    tick(3);
    check("rst_busy",    32'(bus.busy),         32'd0);
    check("rst_done",    32'(bus.done),         32'd0);
    check("rst_err",     32'(bus.err_timeout),  32'd0);
    check("rst_sready",  32'(bus.s_ready),      32'd0);
    check("rst_cvvalid", 32'(bus.cv_din_valid), 32'd0);
    check("rst_cvrgb",   {8'd0, bus.cv_r, bus.cv_g, bus.cv_b}, 32'd0);
    check("rst_mvalid",  32'(bus.m_valid),      32'd0);
    check("rst_mflags",  {bus.m_gray, bus.m_sof, bus.m_eol, bus.m_eof}, 32'd0);
    rst = 1'b0;
    tick(2);

    // 4x2 white frame, source always valid
    clr_stats();
    set_pix(8'd255, 8'd255, 8'd255);
    bus.s_valid = 1'b1;
    do_start(4, 2);
    check("f1_busy", 32'(bus.busy), 32'd1);
    wait_done("f1_done_seen", 200);
    tick();
    check("f1_done_pulse", 32'(bus.done), 32'd0);
    check("f1_busy_after", 32'(bus.busy), 32'd0);
    bus.s_valid = 1'b0;
    tick(3);
    check("f1_hs",      n_hs,    32'd8);
    check("f1_din",     n_din,   32'd8);
    check("f1_din_run", max_run, 32'd8);
    check("f1_nout",    n_out,   32'd8);
    check("f1_gray",    {g_and, g_or}, {8'd255, 8'd255});
    check("f1_sof",     sof_m,   32'h01);
    check("f1_eol",     eol_m,   32'h88);
    check("f1_eof",     eof_m,   32'h80);
    check("f1_ndone",   n_done,  32'd1);

    // 3x1 black frame, source valid toggling
    clr_stats();
    set_pix(8'd0, 8'd0, 8'd0);
    do_start(3, 1);
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = (i % 2 == 0);
      tick();
    end
    bus.s_valid = 1'b0;
    wait_done("f2_done_seen", 200);
    tick(3);
    check("f2_hs",    n_hs,    32'd3);
    check("f2_din",   n_din,   32'd3);
    check("f2_align", n_align, 32'd3);
    check("f2_nout",  n_out,   32'd3);
    check("f2_gray",  g_or,    32'd0);
    check("f2_flags", {eol_m[7:0], eof_m[7:0], sof_m[7:0]}, {8'h04, 8'h04, 8'h01});
    check("f2_ndone", n_done,  32'd1);

    // Zero-width frame
    clr_stats();
    do_start(0, 5);
    wait_done("f3_done_seen", 20);
    tick(3);
    check("f3_latency", 32'(done_cyc - start_cyc), 32'd2);
    check("f3_sready",  n_sready, 32'd0);
    check("f3_nout",    n_out,    32'd0);
    check("f3_err",     32'(bus.err_timeout), 32'd0);
    check("f3_ndone",   n_done,   32'd1);

    // Converter silent: drain watchdog fires
    clr_stats();
    mode = 1;
    set_pix(8'd1, 8'd2, 8'd3);
    bus.s_valid = 1'b1;
    do_start(2, 2);
    wait_done("f4_done_seen", 300);
    check("f4_err_at_done", 32'(bus.err_timeout), 32'd1);
    tick(3);
    check("f4_latency", 32'(done_cyc - start_cyc), 32'd70);
    check("f4_hs",      n_hs,  32'd4);
    check("f4_nout",    n_out, 32'd0);
    check("f4_ndone",   n_done, 32'd1);
    check("f4_err_sticky", 32'(bus.err_timeout), 32'd1);
    mode = 0;
    tick(2);
    clr_stats();
    do_start(1, 1);
    check("f4_err_cleared", 32'(bus.err_timeout), 32'd0);
    wait_done("f4b_done_seen", 50);
    bus.s_valid = 1'b0;
    tick(3);
    check("f4b_nout", n_out, 32'd1);

    // Reset in the middle of a 4x2 frame
    clr_stats();
    set_pix(8'd255, 8'd255, 8'd255);
    bus.s_valid = 1'b1;
    do_start(4, 2);
    for (int k = 0; k < 50 && n_hs < 3; k++) tick();
    check("f5_hs_before_rst", n_hs, 32'd3);
    rst = 1'b1;
    bus.s_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("f5_busy",   32'(bus.busy),    32'd0);
    check("f5_sready", 32'(bus.s_ready), 32'd0);
    check("f5_mvalid", 32'(bus.m_valid), 32'd0);
    clr_stats();
    mode = 2;
    for (int i = 0; i < 6; i++) begin
      man_pulse = (i % 2 == 0);
      tick();
    end
    man_pulse = 1'b0;
    tick(2);
    check("f5_late_nout", n_out,  32'd0);
    check("f5_late_done", n_done, 32'd0);
    mode = 0;
    tick(2);
    clr_stats();
    set_pix(8'd10, 8'd20, 8'd30);
    bus.s_valid = 1'b1;
    do_start(1, 1);
    wait_done("f5b_done_seen", 50);
    bus.s_valid = 1'b0;
    tick(3);
    check("f5b_nout",  n_out, 32'd1);
    check("f5b_flags", {sof_m[0], eol_m[0], eof_m[0]}, 32'b111);
    check("f5b_gray",  last_gray, 32'd18);
    check("f5b_ndone", n_done, 32'd1);

    // Second start during RUN of a 4x4 frame is ignored
    clr_stats();
    set_pix(8'd100, 8'd50, 8'd200);
    bus.s_valid = 1'b1;
    do_start(4, 4);
    tick(3);
    bus.cfg_width  = DIM_W'(2);
    bus.cfg_height = DIM_W'(2);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("f6_done_seen", 300);
    bus.s_valid = 1'b0;
    tick(6);
    check("f6_nout",  n_out,  32'd16);
    check("f6_ndone", n_done, 32'd1);
    check("f6_gray",  {g_and, g_or}, {8'd82, 8'd82});
    check("f6_sof",   sof_m,  32'h0001);
    check("f6_eol",   eol_m,  32'h8888);
    check("f6_eof",   eof_m,  32'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rgb2gray_frame_ctrl.md
Name: rgb2gray_frame_ctrl

Overview:
- Frame sequencer wrapped around the existing rgb2gray pixel converter.
- On a start pulse it pulls exactly cfg_width*cfg_height RGB pixels from an upstream valid/ready source and drives rgb2gray's din_valid and r/g/b inputs.
- It counts rgb2gray's dout_valid results and re-emits them downstream with sof/eol/eof markers, then pulses done.
- It sits between the pixel source (camera/frame buffer reader) and the grayscale consumer.

Parameters:
- DIM_W, 12, width of the frame width/height configuration fields.
- DRAIN_TIMEOUT, 64, max cycles waited in DRAIN for outstanding results before aborting.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start request; one-cycle pulse.
- cfg_width  in  DIM_W  pixels per line; latched on accepted start.
- cfg_height  in  DIM_W  lines per frame; latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse at frame end.
- err_timeout  out  1  sticky; set on drain timeout; cleared by the next accepted start.
- s_valid  in  1  upstream pixel valid.
- s_ready  out  1  upstream pixel ready.
- s_r, s_g, s_b  in  8 each  upstream pixel components.
- cv_din_valid  out  1  to rgb2gray din_valid.
- cv_r, cv_g, cv_b  out  8 each  to rgb2gray r_data/g_data/b_data.
- cv_dout_valid  in  1  from rgb2gray dout_valid.
- cv_gray  in  8  from rgb2gray gray_data.
- m_valid  out  1  downstream gray valid; downstream has no backpressure.
- m_gray  out  8  gray pixel.
- m_sof, m_eol, m_eof  out  1 each  start of frame, end of line, end of frame; qualified by m_valid.

Behaviour:
- Reset, while rst=1 at a clk edge:
  - state=IDLE, all counters 0.
  - All outputs 0: busy, done, err_timeout, s_ready, cv_din_valid, cv_r/g/b, m_valid, m_gray, m_sof/m_eol/m_eof.
  - Reset mid-frame abandons the frame with no done pulse.
  - cv_dout_valid pulses arriving later in IDLE are dropped, with no m_valid.
- States IDLE, RUN, DRAIN, DONE:
  - IDLE: start=1 latches cfg and clears err_timeout. If cfg_width==0 or cfg_height==0, go to DONE with no pixels issued; otherwise go to RUN. start while not IDLE is ignored.
  - RUN: s_ready = (in_cnt < total), combinational from registered state and count. Each s_valid&&s_ready cycle increments in_cnt. After the handshake that makes in_cnt==total, go to DRAIN.
  - DRAIN: wait until out_cnt==total, then go to DONE. A watchdog counts DRAIN cycles; reaching DRAIN_TIMEOUT sets err_timeout and forces DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- busy = (state != IDLE), registered.
- Input path (registered, 1-cycle latency):
  - cv_din_valid <= s_valid && s_ready; cv_r/g/b <= s_r/g/b on handshake.
  - cv_r/g/b hold their value otherwise.
- Output path (registered, 1-cycle latency from cv_dout_valid):
  - m_valid <= cv_dout_valid, only in RUN or DRAIN and only while out_cnt < total. Excess results are dropped.
  - m_gray <= cv_gray.
  - Output x/y counters, where x counts 0..width-1 and y counts 0..height-1:
    - m_sof = (x==0 && y==0).
    - m_eol = (x==width-1).
    - m_eof = (x==width-1 && y==height-1).
    - x wraps to 0 and y increments at end of line.
- total = width*height, computed once at start into a 2*DIM_W-bit register.
- Input and output sides are independent. Results may arrive in RUN while inputs are still being accepted; a simultaneous input handshake and output result in the same cycle are both processed.
- A 1x1 frame produces one m_valid with sof, eol and eof all high.
- done asserts in the cycle after the final m_valid at the earliest.

Decomposition:
- Package rgb2gray_pkg:
  - state enum (IDLE/RUN/DRAIN/DONE, 2-bit encoding).
  - PIX_W=8.
  - default DIM_W and DRAIN_TIMEOUT constants.
- One sub-module, rgb2gray_pos_cnt: an x/y raster counter with enable, clear, width/height inputs and sol/eol/eof outputs. It is instantiated once for the input side (in_cnt) and once for the output side (m_* flags).

Test Plan:
- 4x2 frame, s_valid held 1, rgb2gray in the loop, all pixels 255/255/255:
  - 8 handshakes, cv_din_valid high for 8 consecutive cycles.
  - 8 m_valid with m_gray=255.
  - m_sof on pixel 0, m_eol on pixels 3 and 7, m_eof on pixel 7 only.
  - done one cycle, then busy=0.
- 3x1 frame with s_valid toggling 1,0,1,0,1, pixels 0/0/0 -> exactly 3 cv_din_valid pulses aligned to the handshakes, 3 m_valid with m_gray=0, done asserted once.
- start with cfg_width=0, cfg_height=5 -> no s_ready, no m_valid, done pulse exactly 2 cycles after start, err_timeout=0.
- 2x2 frame with cv_dout_valid tied low by the bench model (rgb2gray replaced) -> DRAIN for DRAIN_TIMEOUT=64 cycles, then err_timeout=1 and done pulses; the next start clears err_timeout.
- rst=1 for one cycle mid-frame after 3 of 8 pixels:
  - next cycle busy=0, s_ready=0, m_valid=0.
  - late cv_dout_valid pulses produce no m_valid.
  - a new 1x1 frame completes with m_sof=m_eol=m_eof=1.
- start pulsed again during RUN of a 4x4 frame -> ignored; exactly 16 outputs and one done.
